// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 constants, the sequencer state encoding and the byte-level
// helper functions used by the round datapath.
//   AES_NR      : number of AES-128 rounds
//   AES_BLK_W   : block / key width in bits
//   AES_RND_W   : width of the round index
//   aes_state_e : sequencer states IDLE / ROUND / FINAL / DONE
//   aes_sbox    : forward S-box lookup
//   aes_xtime   : multiply by x in GF(2^8)
//   aes_rcon    : key-schedule round constant for rounds 1..10
// Byte ordering everywhere: bit 0 of a block is the MSB of byte 0, and bytes
// are laid out column-major (byte i sits at row i%4, column i/4).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;
    localparam int AES_RND_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    // S-box flattened so that entry n lives in bits [8n : 8n+7].
    localparam logic [0:2047] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return AES_SBOX[8*int'(b) +: 8];
    endfunction

    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rounds outside 1..10 never reach the key schedule in a useful cycle,
    // so they simply map to zero.
    function automatic logic [7:0] aes_rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/Add_round_key.sv
// -----------------------------------------------------------------------------
// Add_round_key
// XORs a round key into the state.
//   data_in   : state
//   round_key : key for this round
//   data_out  : state ^ round_key
// -----------------------------------------------------------------------------
module Add_round_key
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] data_in,
    input  logic [0:AES_BLK_W-1] round_key,
    output logic [0:AES_BLK_W-1] data_out
);

    assign data_out = data_in ^ round_key;

endmodule

// File: rtl/Round.sv
// -----------------------------------------------------------------------------
// Round
// One full AES round (rounds 1..9): SubBytes, ShiftRows, MixColumns, then
// AddRoundKey with the key generated for this round.
//   data_in      : state entering the round
//   previous_key : key of the preceding round
//   round        : round index
//   round_key    : key generated for this round
//   data_out     : state leaving the round
// -----------------------------------------------------------------------------
module Round
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] data_in,
    input  logic [0:AES_BLK_W-1] previous_key,
    input  logic [0:AES_RND_W-1] round,
    output logic [0:AES_BLK_W-1] round_key,
    output logic [0:AES_BLK_W-1] data_out
);

    logic [0:AES_BLK_W-1] sb, sr, mc;

    sub_bytes     u_sub   (.data_in(data_in), .data_out(sb));
    shift_rows    u_shift (.data_in(sb),      .data_out(sr));
    mix_columns   u_mix   (.data_in(sr),      .data_out(mc));
    key_maker     u_key   (.previous_key(previous_key), .round(round), .round_key(round_key));
    Add_round_key u_ark   (.data_in(mc), .round_key(round_key), .data_out(data_out));

endmodule

// File: rtl/aes_final_round.sv
// -----------------------------------------------------------------------------
// aes_final_round
// The last AES round: identical to Round but without MixColumns.
//   data_in      : state entering round 10
//   previous_key : round-9 key
//   round        : round index (10 in normal use)
//   round_key    : round-10 key
//   data_out     : ciphertext
// -----------------------------------------------------------------------------
module aes_final_round
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] data_in,
    input  logic [0:AES_BLK_W-1] previous_key,
    input  logic [0:AES_RND_W-1] round,
    output logic [0:AES_BLK_W-1] round_key,
    output logic [0:AES_BLK_W-1] data_out
);

    logic [0:AES_BLK_W-1] sb, sr;

    sub_bytes     u_sub   (.data_in(data_in), .data_out(sb));
    shift_rows    u_shift (.data_in(sb),      .data_out(sr));
    key_maker     u_key   (.previous_key(previous_key), .round(round), .round_key(round_key));
    Add_round_key u_ark   (.data_in(sr), .round_key(round_key), .data_out(data_out));

endmodule

// File: rtl/key_maker.sv
// -----------------------------------------------------------------------------
// key_maker
// One step of the AES-128 key schedule: derives the key for 'round' from the
// key of the preceding round.
//   previous_key : key of round-1 (the cipher key when round = 1)
//   round        : round index 1..10, selects Rcon
//   round_key    : key for this round
// -----------------------------------------------------------------------------
module key_maker
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] previous_key,
    input  logic [0:AES_RND_W-1] round,
    output logic [0:AES_BLK_W-1] round_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    // temp = SubWord(RotWord(w3)) ^ Rcon; each new word chains on the last.
    always_comb begin
        w0   = previous_key[0:31];
        w1   = previous_key[32:63];
        w2   = previous_key[64:95];
        w3   = previous_key[96:127];
        temp = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]),
                aes_sbox(w3[7:0]),   aes_sbox(w3[31:24])}
             ^ {aes_rcon(round), 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        round_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/mix_columns.sv
// -----------------------------------------------------------------------------
// mix_columns
// Multiplies each state column by the fixed MixColumns matrix over GF(2^8).
//   data_in  : 128-bit block, column-major
//   data_out : mixed block
// -----------------------------------------------------------------------------
module mix_columns
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] data_in,
    output logic [0:AES_BLK_W-1] data_out
);

    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        data_out = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = data_in[32*c      +: 8];
            a1 = data_in[32*c + 8  +: 8];
            a2 = data_in[32*c + 16 +: 8];
            a3 = data_in[32*c + 24 +: 8];
            data_out[32*c      +: 8] = aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3;
            data_out[32*c + 8  +: 8] = a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3;
            data_out[32*c + 16 +: 8] = a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3;
            data_out[32*c + 24 +: 8] = aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3);
        end
    end

endmodule

// File: rtl/shift_rows.sv
// -----------------------------------------------------------------------------
// shift_rows
// Cyclically rotates row r of the state left by r byte positions.
//   data_in  : 128-bit block, column-major
//   data_out : shifted block
// -----------------------------------------------------------------------------
module shift_rows
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] data_in,
    output logic [0:AES_BLK_W-1] data_out
);

    // Output byte at (row r, column c) takes input byte at (r, (c+r) mod 4).
    always_comb begin
        data_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                data_out[8*(4*c+r) +: 8] = data_in[8*(4*((c+r)%4)+r) +: 8];
            end
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// -----------------------------------------------------------------------------
// sub_bytes
// Applies the AES S-box to each of the 16 bytes of a block.
//   data_in  : 128-bit block
//   data_out : substituted block
// -----------------------------------------------------------------------------
module sub_bytes
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] data_in,
    output logic [0:AES_BLK_W-1] data_out
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < 16; i++) begin
            data_out[8*i +: 8] = aes_sbox(data_in[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
// Iterative AES-128 encryptor. Accepts a plaintext/key pair, applies the
// initial AddRoundKey, runs Round for rounds 1..NR-1 and aes_final_round for
// round NR, one round per clock, then presents the ciphertext until taken.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   in_valid    : plaintext/key present
//   in_ready    : high in IDLE only
//   plaintext   : input block
//   cipher_key  : AES-128 key
//   out_valid   : high in DONE only
//   out_ready   : consumer takes ciphertext
//   ciphertext  : always state_q; meaningful while out_valid
//   busy        : high in ROUND and FINAL
// -----------------------------------------------------------------------------
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:AES_BLK_W-1] plaintext,
    input  logic [0:AES_BLK_W-1] cipher_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:AES_BLK_W-1] ciphertext,
    output logic                 busy
);

    localparam logic [0:AES_RND_W-1] LAST_FULL_RND = AES_RND_W'(NR - 1);

    aes_state_e           fsm_q,   fsm_d;
    logic [0:AES_BLK_W-1] state_q, state_d;
    logic [0:AES_BLK_W-1] key_q,   key_d;
    logic [0:AES_RND_W-1] rnd_q,   rnd_d;

    logic [0:AES_BLK_W-1] round_data, round_key;
    logic [0:AES_BLK_W-1] final_data, final_key;

    Round u_round (
        .data_in      (state_q),
        .previous_key (key_q),
        .round        (rnd_q),
        .round_key    (round_key),
        .data_out     (round_data)
    );

    aes_final_round u_final (
        .data_in      (state_q),
        .previous_key (key_q),
        .round        (rnd_q),
        .round_key    (final_key),
        .data_out     (final_data)
    );

    // rnd_q is only advanced in ROUND, so it tops out at NR on entry to FINAL.
    // In FINAL key_q picks up the round-NR key so it ends on the last schedule
    // word rather than a stale one.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ cipher_key;
                    key_d   = cipher_key;
                    rnd_d   = AES_RND_W'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_data;
                key_d   = round_key;
                rnd_d   = rnd_q + AES_RND_W'(1);
                if (rnd_q == LAST_FULL_RND) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                state_d = final_data;
                key_d   = final_key;
                fsm_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    // Handshake outputs decode the registered state only, so neither ready
    // nor valid ever depends combinationally on the other side's handshake.
    assign in_ready   = (fsm_q == IDLE);
    assign out_valid  = (fsm_q == DONE);
    assign busy       = (fsm_q == ROUND) || (fsm_q == FINAL);
    assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
// Directed bench for aes_round_sequencer using the FIPS-197 App. B and C.1
// vectors: latency, backpressure, back-to-back issue, ignored inputs while
// busy and asynchronous reset in mid-block.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    localparam logic [0:127] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] B_R0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [0:127] B_R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [0:127] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C_R0  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [0:127] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int           MAX_WAIT = 40;

    logic         clk       = 1'b0;
    logic         rstN      = 1'b0;
    logic         inValid   = 1'b0;
    logic         inReady;
    logic [0:127] plainText = '0;
    logic [0:127] cipherKey = '0;
    logic         outValid;
    logic         outReady  = 1'b0;
    logic [0:127] cipherText;
    logic         busy;

    int vectorsApplied = 0;
    int miscompares    = 0;

    aes_round_sequencer dut (
        .clk        (clk),
        .rst_n      (rstN),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .plaintext  (plainText),
        .cipher_key (cipherKey),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .ciphertext (cipherText),
        .busy       (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Backstop in case some handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exhausted, got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advances negedge by negedge until out_valid is seen or the budget runs
    // out; k counts clock edges since the accept edge.
    task automatic wait_out_valid(inout int k);
        while (outValid !== 1'b1 && k < MAX_WAIT) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        vectorsApplied++;
        if (inReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", inReady);
        end
        vectorsApplied++;
        if (outValid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got out_valid=%b busy=%b want 0 0", outValid, busy);
        end
        vectorsApplied++;
        if (cipherText !== 128'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_ciphertext: got %h want 0", cipherText);
        end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips_b();
        int k;
        outReady  = 1'b0;
        plainText = B_PT;
        cipherKey = B_KEY;
        inValid   = 1'b1;
        @(negedge clk);
        k = 0;
        inValid = 1'b0;
        vectorsApplied++;
        if (cipherText !== B_R0) begin
            miscompares++;
            $display("[TB] FAIL b_after_e0: got %h want %h", cipherText, B_R0);
        end
        vectorsApplied++;
        if (inReady !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b_busy_flags: got in_ready=%b busy=%b want 0 1", inReady, busy);
        end
        @(negedge clk);
        k = 1;
        vectorsApplied++;
        if (cipherText !== B_R1) begin
            miscompares++;
            $display("[TB] FAIL b_after_e1: got %h want %h", cipherText, B_R1);
        end
        wait_out_valid(k);
        vectorsApplied++;
        if (k != 10) begin
            miscompares++;
            $display("[TB] FAIL b_latency: got %0d want 10", k);
        end
        vectorsApplied++;
        if (cipherText !== B_CT || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b_ciphertext: got %h busy=%b want %h busy=0", cipherText, busy, B_CT);
        end
        outReady = 1'b1;
        @(negedge clk);
        vectorsApplied++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b_handshake: got in_ready=%b out_valid=%b want 1 0", inReady, outValid);
        end
    endtask

    task automatic test_fips_c1();
        int k;
        outReady  = 1'b1;
        plainText = C_PT;
        cipherKey = C_KEY;
        inValid   = 1'b1;
        @(negedge clk);
        k = 0;
        inValid = 1'b0;
        wait_out_valid(k);
        vectorsApplied++;
        if (k != 10) begin
            miscompares++;
            $display("[TB] FAIL c1_latency: got %0d want 10", k);
        end
        vectorsApplied++;
        if (cipherText !== C_CT) begin
            miscompares++;
            $display("[TB] FAIL c1_ciphertext: got %h want %h", cipherText, C_CT);
        end
        @(negedge clk);
        vectorsApplied++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL c1_return_idle: got in_ready=%b out_valid=%b want 1 0", inReady, outValid);
        end
    endtask

    task automatic test_backpressure();
        int k;
        outReady  = 1'b0;
        plainText = C_PT;
        cipherKey = C_KEY;
        inValid   = 1'b1;
        @(negedge clk);
        k = 0;
        inValid = 1'b0;
        wait_out_valid(k);
        vectorsApplied++;
        if (k != 10 || cipherText !== C_CT) begin
            miscompares++;
            $display("[TB] FAIL bp_first: got k=%0d %h want k=10 %h", k, cipherText, C_CT);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectorsApplied++;
            if (cipherText !== C_CT || outValid !== 1'b1 || inReady !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold[%0d]: got %h valid=%b ready=%b want %h valid=1 ready=0",
                         i, cipherText, outValid, inReady, C_CT);
            end
        end
        outReady = 1'b1;
        @(negedge clk);
        vectorsApplied++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", inReady, outValid);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        outReady  = 1'b1;
        plainText = B_PT;
        cipherKey = B_KEY;
        inValid   = 1'b1;
        @(negedge clk);
        k = 0;
        plainText = C_PT;
        cipherKey = C_KEY;
        wait_out_valid(k);
        vectorsApplied++;
        if (k != 10 || cipherText !== B_CT) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got k=%0d %h want k=10 %h", k, cipherText, B_CT);
        end
        @(negedge clk);
        k++;
        vectorsApplied++;
        if (inReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_idle_e11: got in_ready=%b want 1", inReady);
        end
        @(negedge clk);
        k++;
        vectorsApplied++;
        if (inReady !== 1'b0 || cipherText !== C_R0) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept_e12: got ready=%b %h want ready=0 %h", inReady, cipherText, C_R0);
        end
        inValid = 1'b0;
        wait_out_valid(k);
        vectorsApplied++;
        if (k != 22 || cipherText !== C_CT) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: got k=%0d %h want k=22 %h", k, cipherText, C_CT);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int k;
        outReady  = 1'b0;
        plainText = B_PT;
        cipherKey = B_KEY;
        inValid   = 1'b1;
        @(negedge clk);
        k = 0;
        plainText = C_PT;
        cipherKey = C_KEY;
        @(negedge clk);
        k = 1;
        vectorsApplied++;
        if (cipherText !== B_R1) begin
            miscompares++;
            $display("[TB] FAIL busy_round1: got %h want %h", cipherText, B_R1);
        end
        plainText = ~B_PT;
        cipherKey = ~B_KEY;
        wait_out_valid(k);
        vectorsApplied++;
        if (k != 10 || cipherText !== B_CT) begin
            miscompares++;
            $display("[TB] FAIL busy_ciphertext: got k=%0d %h want k=10 %h", k, cipherText, B_CT);
        end
        repeat (2) @(negedge clk);
        vectorsApplied++;
        if (cipherText !== B_CT || inReady !== 1'b0 || outValid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_done_hold: got %h ready=%b valid=%b want %h ready=0 valid=1",
                     cipherText, inReady, outValid, B_CT);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        vectorsApplied++;
        if (inReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_release: got in_ready=%b want 1", inReady);
        end
    endtask

    task automatic test_reset_mid_op();
        int k;
        int pulses;
        outReady  = 1'b1;
        plainText = B_PT;
        cipherKey = B_KEY;
        inValid   = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        vectorsApplied++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0 || cipherText !== 128'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_async: got ready=%b valid=%b busy=%b %h want 1 0 0 0",
                     inReady, outValid, busy, cipherText);
        end
        @(negedge clk);
        rstN = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (outValid === 1'b1) pulses++;
        end
        vectorsApplied++;
        if (pulses != 0 || inReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_no_output: got pulses=%0d ready=%b want 0 1", pulses, inReady);
        end
        plainText = B_PT;
        cipherKey = B_KEY;
        inValid   = 1'b1;
        @(negedge clk);
        k = 0;
        inValid = 1'b0;
        vectorsApplied++;
        if (cipherText !== B_R0) begin
            miscompares++;
            $display("[TB] FAIL rst_rerun_e0: got %h want %h", cipherText, B_R0);
        end
        wait_out_valid(k);
        vectorsApplied++;
        if (k != 10 || cipherText !== B_CT) begin
            miscompares++;
            $display("[TB] FAIL rst_rerun_ct: got k=%0d %h want k=10 %h", k, cipherText, B_CT);
        end
        @(negedge clk);
    endtask

    // Scenarios run in a fixed order; each one leaves the block in IDLE.
    initial begin
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_backpressure();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
